imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning word-address width of the instruction memory (depth 2^ADDR_W words).
REQ-002 The block SHALL have parameter BASE_ADDR, default 0, meaning the first word address written.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to begin a load.
REQ-006 The block SHALL have port word_count, input, ADDR_W+1 bits: number of words to load, sampled only on an accepted start.
REQ-007 The block SHALL have port byte_valid, input, 1 bit: byte_data is valid.
REQ-008 The block SHALL have port byte_data, input, 8 bits: image byte stream, little-endian within each word.
REQ-009 The block SHALL have port byte_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-010 The block SHALL have port im_we, output, 1 bit: instruction-memory write strobe.
REQ-011 The block SHALL have port im_addr, output, ADDR_W bits: instruction-memory word address.
REQ-012 The block SHALL have port im_wdata, output, 32 bits: instruction word to write.
REQ-013 The block SHALL have port cpu_rstn, output, 1 bit: active-low reset to the CPU, held low until the load completes.
REQ-014 The block SHALL have the following status outputs, each 1 bit: busy (load in progress), done (load complete), err (rejected request).
REQ-015 The block SHALL have port checksum, output, 32 bits: XOR of all words written in the current load.

Function
REQ-016 The block SHALL implement the FSM states IDLE, RECV, WRITE, DONE.
REQ-017 From IDLE or DONE, a start with 0 < word_count <= 2^ADDR_W SHALL latch word_count, clear checksum, byte index and word index, drive cpu_rstn=0 and done=0, and enter RECV.
REQ-018 A start with word_count=0 SHALL go directly to DONE with no writes and checksum=0.
REQ-019 A start with word_count > 2^ADDR_W SHALL set err=1, perform no writes, go to IDLE, and hold cpu_rstn=0.
REQ-020 err SHALL stay high until the next accepted start or reset.
REQ-021 byte_ready SHALL be 1 only in RECV.
REQ-022 A byte SHALL be accepted when byte_valid and byte_ready are both 1; byte k of a word (k=0..3) goes to bits [8k+7:8k].
REQ-023 When the 4th byte is accepted in cycle N, the FSM SHALL be in WRITE in cycle N+1 with im_we=1, im_addr=BASE_ADDR+word index (mod 2^ADDR_W), and im_wdata equal to the assembled word.
REQ-024 im_we SHALL be high for exactly one cycle per word; im_addr and im_wdata are don't-care when im_we=0.
REQ-025 In WRITE, checksum SHALL XOR in the word and the word index SHALL increment.
REQ-026 If the written word is the last word, the FSM SHALL go to DONE; otherwise it returns to RECV; peak rate is 5 cycles per word.
REQ-027 While byte_valid=0 in RECV, the FSM SHALL hold its state indefinitely.
REQ-028 In DONE, the block SHALL drive cpu_rstn=1, done=1 and busy=0; checksum holds its value.
REQ-029 busy SHALL be 1 in RECV and WRITE.
REQ-030 start during RECV or WRITE SHALL be ignored.
REQ-031 start in DONE SHALL re-enter a load per REQ-017, and cpu_rstn SHALL fall in the next cycle.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, including in the middle of a load; any partial word is discarded.
REQ-033 Reset values: byte_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_rstn=0, busy=0, done=0, err=0, checksum=0.
REQ-034 Reset SHALL NOT produce an im_we pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the instruction width (32), and the bytes-per-word constant (4).
REQ-036 Byte-to-word assembly SHALL be a sub-module named byte_packer, with outputs word and word_valid.

Verification
REQ-037 Test: rst, then start with word_count=2 and bytes 13,00,50,00,93,00,10,00 back-to-back -> im_we pulses at addr 0 (00500013) and addr 1 (00100093); checksum=00400080; done=1; cpu_rstn=1.
REQ-038 Test: byte_valid gaps of 3 idle cycles between every byte for word_count=1 -> exactly one im_we, 1 cycle after the 4th byte; byte_ready stays high throughout RECV.
REQ-039 Test: word_count=0 -> done=1 on the next cycle, no im_we, checksum=0; word_count=2^ADDR_W+1 -> err=1, no writes, cpu_rstn=0.
REQ-040 Test: rst asserted after 6 of 8 bytes -> IDLE, no further im_we, all outputs at their reset values; a fresh load of 1 word then writes addr BASE_ADDR.
REQ-041 Test: start pulsed mid-load -> ignored, word_count unchanged; start from DONE -> cpu_rstn drops to 0 the following cycle and the reload overwrites from BASE_ADDR.
REQ-042 Test: BASE_ADDR=2^ADDR_W-1 with word_count=2 -> writes wrap to addresses 2^ADDR_W-1 and 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned InstrW       = 32;
  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned ByteIdxW     = $clog2(BytesPerWord);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid flags the cycle
// in which the final byte of a word is accepted, with word already complete.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  output logic [InstrW-1:0] word,
  output logic              word_valid
);

  logic [ByteIdxW-1:0] idx_q, idx_d;
  logic [InstrW-1:0]   acc_q, acc_d;

  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    if (clr) begin
      idx_d = '0;
    end else if (byte_en) begin
      acc_d[8*idx_q +: 8] = byte_data;
      idx_d               = idx_q + 1'b1;
    end
  end

  // Combinational so the top can capture the finished word on the accepting edge.
  assign word       = acc_d;
  assign word_valid = byte_en && !clr && (idx_q == ByteIdxW'(BytesPerWord - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory and holds the CPU in reset
// until the requested number of words has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [InstrW-1:0] im_wdata,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [InstrW-1:0] checksum
);

  localparam logic [ADDR_W:0]   MaxWords = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     widx_q, widx_d;
  logic                err_q, err_d;
  logic [InstrW-1:0]   checksum_q, checksum_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [InstrW-1:0]   im_wdata_q, im_wdata_d;

  logic                pack_clr;
  logic                pack_en;
  logic [InstrW-1:0]   pack_word;
  logic                pack_valid;

  assign pack_en = byte_valid && (state_q == StRecv);

  byte_packer u_byte_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pack_clr),
    .byte_en    (pack_en),
    .byte_data  (byte_data),
    .word       (pack_word),
    .word_valid (pack_valid)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    widx_d     = widx_q;
    err_d      = err_q;
    checksum_d = checksum_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    pack_clr   = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (word_count > MaxWords) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            err_d      = 1'b0;
            count_d    = word_count;
            widx_d     = '0;
            checksum_d = '0;
            pack_clr   = 1'b1;
            state_d    = (word_count == '0) ? StDone : StRecv;
          end
        end
      end
      StRecv: begin
        if (pack_valid) begin
          im_we_d    = 1'b1;
          im_addr_d  = BaseAddr + widx_q[ADDR_W-1:0];
          im_wdata_d = pack_word;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        checksum_d = checksum_q ^ im_wdata_q;
        widx_d     = widx_q + 1'b1;
        state_d    = (widx_d == count_q) ? StDone : StRecv;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      widx_q     <= '0;
      err_q      <= 1'b0;
      checksum_q <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      widx_q     <= widx_d;
      err_q      <= err_d;
      checksum_q <= checksum_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
    end
  end

  assign byte_ready = (state_q == StRecv);
  assign busy       = (state_q == StRecv) || (state_q == StWrite);
  assign done       = (state_q == StDone);
  assign cpu_rstn   = (state_q == StDone);
  assign err        = err_q;
  assign checksum   = checksum_q;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench: stimulus queues expected writes, negedge monitors check them.
module tb_imem_loader;

  localparam int unsigned AW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          start2 = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;

  logic          byte_ready, im_we, cpu_rstn, busy, done, err;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata, checksum;
  logic          byte_ready2, im_we2, cpu_rstn2, busy2, done2, err2;
  logic [AW-1:0] im_addr2;
  logic [31:0]   im_wdata2, checksum2;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  writes1 = 0;
  int  writes2 = 0;
  wr_t exp1[$];
  wr_t exp2[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk (clk), .rst (rst), .start (start), .word_count (word_count),
    .byte_valid (byte_valid), .byte_data (byte_data), .byte_ready (byte_ready),
    .im_we (im_we), .im_addr (im_addr), .im_wdata (im_wdata), .cpu_rstn (cpu_rstn),
    .busy (busy), .done (done), .err (err), .checksum (checksum)
  );

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(2**AW - 1)) dut2 (
    .clk (clk), .rst (rst), .start (start2), .word_count (word_count),
    .byte_valid (byte_valid), .byte_data (byte_data), .byte_ready (byte_ready2),
    .im_we (im_we2), .im_addr (im_addr2), .im_wdata (im_wdata2), .cpu_rstn (cpu_rstn2),
    .busy (busy2), .done (done2), .err (err2), .checksum (checksum2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : mon1
    wr_t e;
    if (im_we) begin
      writes1++;
      if (exp1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut1_unexpected_write: got addr %0d data %h required none", im_addr,
                 im_wdata);
      end else begin
        e = exp1.pop_front();
        chk("dut1_addr", 32'(im_addr), 32'(e.addr));
        chk("dut1_data", im_wdata, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon2
    wr_t e;
    if (im_we2) begin
      writes2++;
      if (exp2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut2_unexpected_write: got addr %0d data %h required none", im_addr2,
                 im_wdata2);
      end else begin
        e = exp2.pop_front();
        chk("dut2_addr", 32'(im_addr2), 32'(e.addr));
        chk("dut2_data", im_wdata2, e.data);
      end
    end
  end

  function automatic logic rdy(input int sel);
    return (sel == 1) ? byte_ready : byte_ready2;
  endfunction

  function automatic logic is_done(input int sel);
    return (sel == 1) ? done : done2;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int sel, input logic [AW:0] wc);
    word_count = wc;
    if (sel == 1) start = 1'b1;
    else start2 = 1'b1;
    sync();
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b);
    int n;
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    @(negedge clk);
    while (!rdy(sel) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(sel)) begin
      n_tests++;
      n_fail++;
      $display("FAIL byte_ready_timeout: got ready 0 required 1 within 40 cycles");
    end
    sync();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input int sel, input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(sel, w[8*k +: 8]);
  endtask

  task automatic wait_done(input int sel);
    int n;
    n = 0;
    @(negedge clk);
    while (!is_done(sel) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!is_done(sel)) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got done 0 required 1 within 60 cycles");
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_im_we"}, 32'(im_we), 32'd0);
    chk({tag, "_im_addr"}, 32'(im_addr), 32'd0);
    chk({tag, "_im_wdata"}, im_wdata, 32'd0);
    chk({tag, "_cpu_rstn"}, 32'(cpu_rstn), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_checksum"}, checksum, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got no finish required finish by 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    int wbase;
    logic [31:0] w;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rst");
    sync();

    // Two back-to-back words from BASE_ADDR 0
    exp1.push_back('{addr: 4'd0, data: 32'h00500013});
    exp1.push_back('{addr: 4'd1, data: 32'h00100093});
    pulse_start(1, 5'd2);
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_cpu_rstn_low", 32'(cpu_rstn), 32'd0);
    chk("t1_byte_ready", 32'(byte_ready), 32'd1);
    sync();
    send_word(1, 32'h00500013);
    send_word(1, 32'h00100093);
    wait_done(1);
    chk("t1_checksum", checksum, 32'h00400080);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cpu_rstn", 32'(cpu_rstn), 32'd1);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    sync();

    // Gapped bytes: three idle cycles between every byte
    wbase = writes1;
    w = 32'h12345678;
    exp1.push_back('{addr: 4'd0, data: w});
    pulse_start(1, 5'd1);
    for (int k = 0; k < 4; k++) begin
      send_byte(1, w[8*k +: 8]);
      if (k < 3) begin
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          chk("t2_ready_in_gap", 32'(byte_ready), 32'd1);
          sync();
        end
      end
    end
    @(negedge clk);
    chk("t2_we_after_4th", 32'(im_we), 32'd1);
    wait_done(1);
    chk("t2_write_count", 32'(writes1 - wbase), 32'd1);
    chk("t2_checksum", checksum, w);
    sync();

    // Zero-length and oversize requests
    rst = 1'b1;
    sync();
    rst = 1'b0;
    pulse_start(1, 5'd0);
    @(negedge clk);
    chk("t3_zero_done", 32'(done), 32'd1);
    chk("t3_zero_checksum", checksum, 32'd0);
    chk("t3_zero_cpu_rstn", 32'(cpu_rstn), 32'd1);
    sync();
    pulse_start(1, 5'd17);
    @(negedge clk);
    chk("t3_big_err", 32'(err), 32'd1);
    chk("t3_big_done", 32'(done), 32'd0);
    chk("t3_big_cpu_rstn", 32'(cpu_rstn), 32'd0);
    chk("t3_big_busy", 32'(busy), 32'd0);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      chk("t3_err_held", 32'(err), 32'd1);
    end
    sync();
    pulse_start(1, 5'd1);
    @(negedge clk);
    chk("t3_err_cleared", 32'(err), 32'd0);
    sync();
    exp1.push_back('{addr: 4'd0, data: 32'hDEADBEEF});
    send_word(1, 32'hDEADBEEF);
    wait_done(1);
    chk("t3_checksum", checksum, 32'hDEADBEEF);
    sync();

    // Reset in the middle of a load
    pulse_start(1, 5'd2);
    exp1.push_back('{addr: 4'd0, data: 32'h44332211});
    send_word(1, 32'h44332211);
    send_byte(1, 8'h55);
    send_byte(1, 8'h66);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("t4_midrst");
    repeat (4) sync();
    pulse_start(1, 5'd1);
    exp1.push_back('{addr: 4'd0, data: 32'h04030201});
    send_word(1, 32'h04030201);
    wait_done(1);
    chk("t4_checksum", checksum, 32'h04030201);
    sync();

    // Start ignored in RECV and WRITE; restart from DONE
    pulse_start(1, 5'd2);
    exp1.push_back('{addr: 4'd0, data: 32'hDDCCBBAA});
    exp1.push_back('{addr: 4'd1, data: 32'h80000001});
    send_byte(1, 8'hAA);
    send_byte(1, 8'hBB);
    pulse_start(1, 5'd1);
    send_byte(1, 8'hCC);
    send_byte(1, 8'hDD);
    pulse_start(1, 5'd1);
    @(negedge clk);
    chk("t5_still_busy", 32'(busy), 32'd1);
    sync();
    send_word(1, 32'h80000001);
    wait_done(1);
    chk("t5_checksum", checksum, 32'h5DCCBBAB);
    chk("t5_cpu_rstn_high", 32'(cpu_rstn), 32'd1);
    sync();
    pulse_start(1, 5'd1);
    @(negedge clk);
    chk("t5_cpu_rstn_fall", 32'(cpu_rstn), 32'd0);
    chk("t5_done_cleared", 32'(done), 32'd0);
    sync();
    exp1.push_back('{addr: 4'd0, data: 32'h0C0D0E0F});
    send_word(1, 32'h0C0D0E0F);
    wait_done(1);
    chk("t5_reload_checksum", checksum, 32'h0C0D0E0F);
    sync();

    // Address wrap with BASE_ADDR at the top of memory
    pulse_start(2, 5'd2);
    exp2.push_back('{addr: 4'd15, data: 32'h87654321});
    exp2.push_back('{addr: 4'd0, data: 32'h76543210});
    send_word(2, 32'h87654321);
    send_word(2, 32'h76543210);
    wait_done(2);
    chk("t6_checksum", checksum2, 32'hF1317131);
    chk("t6_done", 32'(done2), 32'd1);
    chk("t6_writes", 32'(writes2), 32'd2);

    repeat (3) @(negedge clk);
    chk("exp1_drained", 32'(exp1.size()), 32'd0);
    chk("exp2_drained", 32'(exp2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
